x_mem_arb: RTL



---
 rtl/x_mem_arb_if.sv | 60 ++++++
 rtl/x_mem_arb.sv | 127 ++++++++++++
 2 files changed

// File: rtl/x_mem_arb_if.sv
// x_mem_arb_if
//   Bundles every non-clock signal of the two-port memory arbiter.
//   The signals keep the arbiter's own port names.
//   Requester port 0 and port 1:
//     i_rN_valid, i_rN_rnw, i_rN_addr, i_rN_data : request in
//     o_rN_accept, o_rN_data                      : completion and read data out
//   Memory side:
//     o_m_valid, o_m_rnw, o_m_addr, o_m_data      : request towards memory
//     i_m_accept, i_m_data                        : completion and read data from memory
//   Status:
//     o_busy, o_owner, o_err
//   Modports:
//     slave  : the arbiter's view.
//     master : the environment's view (requesters plus memory fabric).
interface x_mem_arb_if;
  logic        i_r0_valid;
  logic        i_r0_rnw;
  logic [31:0] i_r0_addr;
  logic [31:0] i_r0_data;
  logic        o_r0_accept;
  logic [31:0] o_r0_data;

  logic        i_r1_valid;
  logic        i_r1_rnw;
  logic [31:0] i_r1_addr;
  logic [31:0] i_r1_data;
  logic        o_r1_accept;
  logic [31:0] o_r1_data;

  logic        o_m_valid;
  logic        o_m_rnw;
  logic [31:0] o_m_addr;
  logic [31:0] o_m_data;
  logic        i_m_accept;
  logic [31:0] i_m_data;

  logic        o_busy;
  logic        o_owner;
  logic        o_err;

  modport slave (
    input  i_r0_valid, i_r0_rnw, i_r0_addr, i_r0_data,
    output o_r0_accept, o_r0_data,
    input  i_r1_valid, i_r1_rnw, i_r1_addr, i_r1_data,
    output o_r1_accept, o_r1_data,
    output o_m_valid, o_m_rnw, o_m_addr, o_m_data,
    input  i_m_accept, i_m_data,
    output o_busy, o_owner, o_err
  );

  modport master (
    output i_r0_valid, i_r0_rnw, i_r0_addr, i_r0_data,
    input  o_r0_accept, o_r0_data,
    output i_r1_valid, i_r1_rnw, i_r1_addr, i_r1_data,
    input  o_r1_accept, o_r1_data,
    input  o_m_valid, o_m_rnw, o_m_addr, o_m_data,
    output i_m_accept, i_m_data,
    input  o_busy, o_owner, o_err
  );
endinterface

// File: rtl/x_mem_arb.sv
// x_mem_arb
//   Shares one valid/accept memory bus between two requesters.
//   Port 0 is the core's fetch/load/store port. Port 1 is a secondary master.
//   A grant is registered, so arbitration costs one cycle.
//   While granted, the owner's request is forwarded combinationally to memory.
//   Accept and read data are returned to the owner only.
//   A watchdog aborts the transaction after 2^WDOG_W grant cycles without accept.
//   An abort completes the request with 32'hDEAD_BEEF and pulses o_err.
//   Ports:
//     i_clk  : clock, rising edge
//     i_nrst : asynchronous active-low reset
//     bus    : x_mem_arb_if.slave (requesters, memory side, status)
//   Parameter:
//     WDOG_W : watchdog counter width, legal range 2..16
module x_mem_arb #(
  parameter int WDOG_W = 8
) (
  input logic        i_clk,
  input logic        i_nrst,
  x_mem_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [WDOG_W-1:0] WD_MAX     = '1;
  localparam logic [31:0]       ABORT_DATA = 32'hDEAD_BEEF;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [WDOG_W-1:0] wd_q, wd_d;

  logic        sel1;
  logic        owner_valid;
  logic        m_valid;
  logic        acc0, acc1;
  logic        err;
  logic [31:0] rdata0, rdata1;

  // State, round-robin pointer and watchdog.
  // last_q resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state and handshake logic.
  // In IDLE, arbitration only looks at the registered state, so there is
  // no combinational path from a request to o_m_valid.
  // In a grant, the order of precedence is:
  //   owner withdrawal, then memory accept, then watchdog abort.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    wd_d        = wd_q;
    m_valid     = 1'b0;
    acc0        = 1'b0;
    acc1        = 1'b0;
    err         = 1'b0;
    rdata0      = bus.i_m_data;
    rdata1      = bus.i_m_data;
    sel1        = (state_q == GRANT1);
    owner_valid = sel1 ? bus.i_r1_valid : bus.i_r0_valid;

    unique case (state_q)
      IDLE: begin
        if (bus.i_r0_valid && (!bus.i_r1_valid || last_q)) begin
          state_d = GRANT0;
          last_d  = 1'b0;
          wd_d    = '0;
        end else if (bus.i_r1_valid) begin
          state_d = GRANT1;
          last_d  = 1'b1;
          wd_d    = '0;
        end
      end

      GRANT0, GRANT1: begin
        if (!owner_valid) begin
          state_d = IDLE;
        end else if (bus.i_m_accept) begin
          m_valid = 1'b1;
          acc0    = !sel1;
          acc1    = sel1;
          state_d = IDLE;
        end else if (wd_q == WD_MAX) begin
          acc0    = !sel1;
          acc1    = sel1;
          err     = 1'b1;
          state_d = IDLE;
          if (sel1) begin
            rdata1 = ABORT_DATA;
          end else begin
            rdata0 = ABORT_DATA;
          end
        end else begin
          m_valid = 1'b1;
          wd_d    = wd_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Memory bus mux. Outside GRANT1 the buses carry port 0's request.
  assign bus.o_m_valid = m_valid;
  assign bus.o_m_rnw   = sel1 ? bus.i_r1_rnw  : bus.i_r0_rnw;
  assign bus.o_m_addr  = sel1 ? bus.i_r1_addr : bus.i_r0_addr;
  assign bus.o_m_data  = sel1 ? bus.i_r1_data : bus.i_r0_data;

  assign bus.o_r0_accept = acc0;
  assign bus.o_r1_accept = acc1;
  assign bus.o_r0_data   = rdata0;
  assign bus.o_r1_data   = rdata1;

  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_owner = last_q;
  assign bus.o_err   = err;

endmodule
